wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_wb_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write-back arbiter.
// Merges memory-load results and ALU results onto a single registered
// register-file write port. Loads always win. ALU results that cannot be
// written in their arrival cycle wait in a 2-entry in-order FIFO. When the
// FIFO is full and no pop happens, an incoming ALU result is dropped and the
// sticky ovf flag is set.
// Optional feature macro: WB_ARBITER_FWD_EN adds two combinational forwarding
// ports. These ports look up the newest queued entry first and then the
// registered output write.
module wb_arbiter #(
    parameter int NUM_DOMAINS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [3:0]               alu_addr,
    input  logic [NUM_DOMAINS*8-1:0] alu_data,
    input  logic                     ld_valid,
    input  logic [2:0]               ld_addr,
    input  logic [7:0]               ld_data,
`ifdef WB_ARBITER_FWD_EN
    input  logic [3:0]               fwd_addr1,
    input  logic [3:0]               fwd_addr2,
    output logic                     fwd_hit1,
    output logic [NUM_DOMAINS*8-1:0] fwd_data1,
    output logic                     fwd_hit2,
    output logic [NUM_DOMAINS*8-1:0] fwd_data2,
`endif
    output logic                     alu_stall,
    output logic                     wr_en,
    output logic [3:0]               wr_addr,
    output logic [NUM_DOMAINS*8-1:0] wr_data,
    output logic                     wr_RNS,
    output logic                     ovf
);

    localparam int W = NUM_DOMAINS * 8;

    // Write-source select codes
    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_LOAD = 2'd1;
    localparam logic [1:0] SEL_HEAD = 2'd2;
    localparam logic [1:0] SEL_BYP  = 2'd3;

    // Zero-extend an 8-bit load value to the full write-data width
    function automatic logic [W-1:0] zext_load(input logic [7:0] val);
        logic [W-1:0] res;
        res      = {W{1'b0}};
        res[7:0] = val;
        return res;
    endfunction

    // FIFO storage; contents are not reset because validity is tracked by count_r
    logic [3:0]   fifo_addr_r [2];
    logic [W-1:0] fifo_data_r [2];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   count_r;
    logic         ovf_r;

    logic         wr_en_r;
    logic [3:0]   wr_addr_r;
    logic [W-1:0] wr_data_r;
    logic         wr_rns_r;

    logic [1:0]   sel_s;
    logic         full_s;
    logic         pop_s;
    logic         push_s;
    logic         drop_s;
    logic [1:0]   count_nxt_s;
    logic [3:0]   nxt_addr_s;
    logic [W-1:0] nxt_data_s;
    logic         nxt_rns_s;

    assign full_s    = (count_r == 2'd2);
    assign alu_stall = full_s;

    // Priority selection: load, then FIFO head, then direct ALU bypass on empty FIFO
    always_comb begin
        sel_s = SEL_NONE;
        if (ld_valid) begin
            sel_s = SEL_LOAD;
        end else if (count_r != 2'd0) begin
            sel_s = SEL_HEAD;
        end else if (alu_valid) begin
            sel_s = SEL_BYP;
        end else begin
            sel_s = SEL_NONE;
        end
    end

    // FIFO control: pop on head select; queue an unselected ALU result unless there is no room
    always_comb begin
        pop_s  = (sel_s == SEL_HEAD);
        push_s = 1'b0;
        drop_s = 1'b0;
        if (alu_valid && (sel_s != SEL_BYP)) begin
            if (full_s && !pop_s) begin
                drop_s = 1'b1;
            end else begin
                push_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // Next occupancy; push together with pop leaves the count unchanged
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // Write-port payload for the selected source
    always_comb begin
        case (sel_s)
            SEL_LOAD: begin
                nxt_addr_s = {1'b0, ld_addr};
                nxt_data_s = zext_load(ld_data);
                nxt_rns_s  = 1'b0;
            end
            SEL_HEAD: begin
                nxt_addr_s = fifo_addr_r[rd_ptr_r];
                nxt_data_s = fifo_data_r[rd_ptr_r];
                nxt_rns_s  = fifo_addr_r[rd_ptr_r][3];
            end
            SEL_BYP: begin
                nxt_addr_s = alu_addr;
                nxt_data_s = alu_data;
                nxt_rns_s  = alu_addr[3];
            end
            default: begin
                nxt_addr_s = wr_addr_r;
                nxt_data_s = wr_data_r;
                nxt_rns_s  = wr_rns_r;
            end
        endcase
    end

    // FIFO payload write at the tail
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= alu_addr;
            fifo_data_r[wr_ptr_r] <= alu_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            count_r <= count_nxt_s;
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Registered write port; address/data/RNS hold when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= 4'd0;
            wr_data_r <= {W{1'b0}};
            wr_rns_r  <= 1'b0;
        end else begin
            wr_en_r   <= (sel_s != SEL_NONE);
            wr_addr_r <= nxt_addr_s;
            wr_data_r <= nxt_data_s;
            wr_rns_r  <= nxt_rns_s;
        end
    end

    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;
    assign wr_RNS  = wr_rns_r;
    assign ovf     = ovf_r;

`ifdef WB_ARBITER_FWD_EN
    logic         newest_idx_s;
    logic [W:0]   fwd1_s;
    logic [W:0]   fwd2_s;

    // The newest queued entry sits one slot behind the write pointer
    assign newest_idx_s = wr_ptr_r - 1'b1;

    // Forward lookup: newest queued entry wins over the registered output write
    function automatic logic [W:0] fwd_lookup(
        input logic [3:0]   addr,
        input logic         q_valid,
        input logic [3:0]   q_addr,
        input logic [W-1:0] q_data,
        input logic         o_valid,
        input logic [3:0]   o_addr,
        input logic [W-1:0] o_data
    );
        logic [W:0] res;
        res = {1'b0, {W{1'b0}}};
        if (q_valid && (q_addr == addr)) begin
            res = {1'b1, q_data};
        end else if (o_valid && (o_addr == addr)) begin
            res = {1'b1, o_data};
        end else begin
            res = {1'b0, {W{1'b0}}};
        end
        return res;
    endfunction

    // Combinational forwarding for both read ports
    always_comb begin
        fwd1_s = fwd_lookup(fwd_addr1, (count_r != 2'd0), fifo_addr_r[newest_idx_s],
                            fifo_data_r[newest_idx_s], wr_en_r, wr_addr_r, wr_data_r);
        fwd2_s = fwd_lookup(fwd_addr2, (count_r != 2'd0), fifo_addr_r[newest_idx_s],
                            fifo_data_r[newest_idx_s], wr_en_r, wr_addr_r, wr_data_r);
    end

    assign fwd_hit1  = fwd1_s[W];
    assign fwd_data1 = fwd1_s[W-1:0];
    assign fwd_hit2  = fwd2_s[W];
    assign fwd_data2 = fwd2_s[W-1:0];
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle
// against a queue-based behavioural model. Forwarding checks are compiled
// when WB_ARBITER_FWD_EN is defined.
module tb_wb_arbiter;

    localparam int ND = 2;
    localparam int W  = ND * 8;

    logic         clk;
    logic         reset;
    logic         alu_valid;
    logic [3:0]   alu_addr;
    logic [W-1:0] alu_data;
    logic         ld_valid;
    logic [2:0]   ld_addr;
    logic [7:0]   ld_data;
    logic         alu_stall;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [W-1:0] wr_data;
    logic         wr_RNS;
    logic         ovf;
`ifdef WB_ARBITER_FWD_EN
    logic [3:0]   fwd_addr1, fwd_addr2;
    logic         fwd_hit1, fwd_hit2;
    logic [W-1:0] fwd_data1, fwd_data2;
`endif

    wb_arbiter #(.NUM_DOMAINS(ND)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
`ifdef WB_ARBITER_FWD_EN
        .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
        .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
        .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
`endif
        .alu_stall(alu_stall), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_RNS(wr_RNS), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a queue of waiting ALU results plus the expected write port
    typedef struct {
        logic [3:0]   a;
        logic [W-1:0] d;
    } ent_t;
    ent_t         q[$];
    logic         m_en   = 1'b0;
    logic [3:0]   m_addr = 4'd0;
    logic [W-1:0] m_data = '0;
    logic         m_rns  = 1'b0;
    logic         m_ovf  = 1'b0;
    logic         chk_en = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model step, applied at the clock edge with the inputs of that cycle
    task automatic model_step();
        ent_t e;
        if (reset) begin
            q.delete();
            m_ovf = 1'b0; m_en = 1'b0; m_addr = 4'd0; m_data = '0; m_rns = 1'b0;
        end else begin
            e.a = alu_addr;
            e.d = alu_data;
            if (ld_valid) begin
                m_en = 1'b1; m_addr = {1'b0, ld_addr}; m_data = W'(ld_data); m_rns = 1'b0;
                if (alu_valid) begin
                    if (q.size() < 2) q.push_back(e);
                    else m_ovf = 1'b1;
                end
            end else if (q.size() > 0) begin
                e = q.pop_front();
                m_en = 1'b1; m_addr = e.a; m_data = e.d; m_rns = e.a[3];
                if (alu_valid) begin
                    e.a = alu_addr;
                    e.d = alu_data;
                    q.push_back(e);
                end
            end else if (alu_valid) begin
                m_en = 1'b1; m_addr = alu_addr; m_data = alu_data; m_rns = alu_addr[3];
            end else begin
                m_en = 1'b0;
            end
        end
    endtask

    // One cycle: drive inputs, advance the clock, update the model, settle past the edge
    task automatic cyc(input logic rst, input logic lv, input logic [2:0] la, input logic [7:0] ld,
                       input logic av, input logic [3:0] aa, input logic [W-1:0] ad);
        reset = rst; ld_valid = lv; ld_addr = la; ld_data = ld;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 4'd0, '0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 4'd0, '0);
    endtask

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_en", 64'(wr_en), 64'(m_en));
            if (m_en) begin
                chk("wr_addr", 64'(wr_addr), 64'(m_addr));
                chk("wr_data", 64'(wr_data), 64'(m_data));
                chk("wr_RNS", 64'(wr_RNS), 64'(m_rns));
            end
            chk("alu_stall", 64'(alu_stall), 64'(q.size() == 2));
            chk("ovf", 64'(ovf), 64'(m_ovf));
`ifdef WB_ARBITER_FWD_EN
            begin
                logic h1, h2;
                logic [W-1:0] d1, d2;
                h1 = 1'b0; h2 = 1'b0; d1 = '0; d2 = '0;
                if (q.size() > 0 && q[q.size()-1].a == fwd_addr1) begin h1 = 1'b1; d1 = q[q.size()-1].d; end
                else if (m_en && m_addr == fwd_addr1) begin h1 = 1'b1; d1 = m_data; end
                if (q.size() > 0 && q[q.size()-1].a == fwd_addr2) begin h2 = 1'b1; d2 = q[q.size()-1].d; end
                else if (m_en && m_addr == fwd_addr2) begin h2 = 1'b1; d2 = m_data; end
                chk("fwd_hit1", 64'(fwd_hit1), 64'(h1));
                chk("fwd_hit2", 64'(fwd_hit2), 64'(h2));
                if (h1) chk("fwd_data1", 64'(fwd_data1), 64'(d1));
                if (h2) chk("fwd_data2", 64'(fwd_data2), 64'(d2));
            end
`endif
        end
    end

    initial begin
`ifdef WB_ARBITER_FWD_EN
        fwd_addr1 = 4'd0; fwd_addr2 = 4'd0;
`endif
        do_reset();
        chk_en = 1'b1;
        chk("reset wr_en", 64'(wr_en), 64'd0);
        chk("reset wr_addr", 64'(wr_addr), 64'd0);
        chk("reset wr_data", 64'(wr_data), 64'd0);
        chk("reset ovf", 64'(ovf), 64'd0);
        do_reset();

        // ALU bypass to the RNS file on an empty FIFO
        cyc(1'b0, 1'b0, 3'd0, 8'd0, 1'b1, 4'hA, 16'h1234);
        chk("byp wr_en", 64'(wr_en), 64'd1);
        chk("byp wr_addr", 64'(wr_addr), 64'hA);
        chk("byp wr_data", 64'(wr_data), 64'h1234);
        chk("byp wr_RNS", 64'(wr_RNS), 64'd1);
        idle();
        chk("idle wr_en", 64'(wr_en), 64'd0);
        chk("idle hold addr", 64'(wr_addr), 64'hA);

        // Load beats a simultaneous ALU result
        cyc(1'b0, 1'b1, 3'd3, 8'h5C, 1'b1, 4'h2, 16'hBEEF);
        chk("ld first addr", 64'(wr_addr), 64'd3);
        chk("ld first data", 64'(wr_data), 64'h005C);
        chk("ld first RNS", 64'(wr_RNS), 64'd0);
        idle();
        chk("alu second en", 64'(wr_en), 64'd1);
        chk("alu second addr", 64'(wr_addr), 64'd2);
        chk("alu second data", 64'(wr_data), 64'hBEEF);
        idle();

        // Three back-to-back loads with ALU results: third ALU result dropped
        do_reset();
        cyc(1'b0, 1'b1, 3'd0, 8'h11, 1'b1, 4'h1, 16'h1111);
        chk("c0 stall", 64'(alu_stall), 64'd0);
        cyc(1'b0, 1'b1, 3'd1, 8'h22, 1'b1, 4'h2, 16'h2222);
        chk("c1 stall", 64'(alu_stall), 64'd1);
        chk("c1 ovf", 64'(ovf), 64'd0);
        cyc(1'b0, 1'b1, 3'd2, 8'h33, 1'b1, 4'h3, 16'h3333);
        chk("c2 ovf", 64'(ovf), 64'd1);
        chk("c2 data", 64'(wr_data), 64'h0033);
        idle();
        chk("drain1 data", 64'(wr_data), 64'h1111);
        idle();
        chk("drain2 data", 64'(wr_data), 64'h2222);
        idle();
        chk("drain3 en", 64'(wr_en), 64'd0);
        chk("ovf sticky", 64'(ovf), 64'd1);

        // Full FIFO with no load: pop and push in the same cycle
        do_reset();
        cyc(1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 4'h4, 16'h4444);
        cyc(1'b0, 1'b1, 3'd1, 8'h01, 1'b1, 4'hC, 16'h5555);
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 4'h6, 16'h6666);
        chk("pp addr", 64'(wr_addr), 64'h4);
        chk("pp data", 64'(wr_data), 64'h4444);
        chk("pp stall", 64'(alu_stall), 64'd1);
        chk("pp ovf", 64'(ovf), 64'd0);
        idle();
        chk("pp next data", 64'(wr_data), 64'h5555);
        chk("pp next RNS", 64'(wr_RNS), 64'd1);
        idle();
        chk("pp last data", 64'(wr_data), 64'h6666);
        idle();

        // Reset with a full FIFO and ovf set discards everything
        cyc(1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 4'h7, 16'h7777);
        cyc(1'b0, 1'b1, 3'd1, 8'h01, 1'b1, 4'h8, 16'h8888);
        cyc(1'b0, 1'b1, 3'd2, 8'h02, 1'b1, 4'h9, 16'h9999);
        chk("pre-rst ovf", 64'(ovf), 64'd1);
        do_reset();
        chk("rst wr_en", 64'(wr_en), 64'd0);
        chk("rst stall", 64'(alu_stall), 64'd0);
        chk("rst ovf", 64'(ovf), 64'd0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("post-rst no write", 64'(wr_en), 64'd0);
        end

`ifdef WB_ARBITER_FWD_EN
        // Forwarding from a queued entry and from the registered write
        cyc(1'b0, 1'b1, 3'd0, 8'h77, 1'b1, 4'h9, 16'h9A9A);
        fwd_addr1 = 4'h9; fwd_addr2 = 4'h0;
        #1;
        chk("fwd1 hit", 64'(fwd_hit1), 64'd1);
        chk("fwd1 data", 64'(fwd_data1), 64'h9A9A);
        chk("fwd2 hit", 64'(fwd_hit2), 64'd1);
        chk("fwd2 data", 64'(fwd_data2), 64'h0077);
        idle();
        idle();
`endif

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
`ifdef WB_ARBITER_FWD_EN
            fwd_addr1 = 4'($urandom_range(0, 15));
            fwd_addr2 = 4'($urandom_range(0, 15));
`endif
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 99) < 35),
                3'($urandom_range(0, 7)),
                8'($urandom),
                ($urandom_range(0, 99) < 60),
                4'($urandom_range(0, 15)),
                W'($urandom));
        end
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
